// File: rtl/voice_seq_pkg.sv
// voice_seq_pkg: shared FSM state codes, step byte layout and step decode helpers.
// Steps are stored big-endian: byte n of a step lives at word bits [31-8n -: 8].
package voice_seq_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  localparam int unsigned STEP_BYTES = 4;

  localparam int unsigned FREQ_HI = 0;
  localparam int unsigned FREQ_LO = 1;
  localparam int unsigned CTRL    = 2;
  localparam int unsigned DUR     = 3;

  localparam int unsigned CTRL_END     = 7;
  localparam int unsigned CTRL_REST    = 6;
  localparam int unsigned CTRL_WAVE_HI = 3;
  localparam int unsigned CTRL_WAVE_LO = 0;

  typedef struct packed {
    logic [15:0] freq;
    logic        last;
    logic        rest;
    logic [3:0]  wave;
    logic [7:0]  dur;
  } step_t;

  // Bit offset of byte lane n inside a 32-bit step word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] n);
    return {~n, 3'b000};
  endfunction

  function automatic step_t unpack_step(input logic [31:0] w);
    step_t      s;
    logic [7:0] ctrl;
    ctrl   = w[lane_lsb(2'(CTRL)) +: 8];
    s.freq = {w[lane_lsb(2'(FREQ_HI)) +: 8], w[lane_lsb(2'(FREQ_LO)) +: 8]};
    s.last = ctrl[CTRL_END];
    s.rest = ctrl[CTRL_REST];
    s.wave = ctrl[CTRL_WAVE_HI:CTRL_WAVE_LO];
    s.dur  = w[lane_lsb(2'(DUR)) +: 8];
    return s;
  endfunction

endpackage

// File: rtl/voice_seq_ram.sv
// voice_seq_ram: STEPS x 32-bit step store with an ioctl byte-lane write port
// and a one-cycle registered 32-bit read port for the sequencer FSM.
module voice_seq_ram
  import voice_seq_pkg::*;
#(
  parameter int unsigned STEPS = 64,
  parameter int unsigned AW    = $clog2(STEPS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [1:0]    i_lane,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [STEPS];
  logic [31:0] r_rdata;

  // Contents are deliberately not reset; the host reloads patterns after power-up.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr][lane_lsb(i_lane) +: 8] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/voice_seq.sv
// voice_seq: step sequencer that plays a pattern from step RAM into one synth voice.
// Optional macro VOICE_SEQ_TEMPO_EN adds a runtime tempo_div input overriding TICK_DIV.
module voice_seq
  import voice_seq_pkg::*;
#(
  parameter int unsigned STEPS     = 64,
  parameter int unsigned TICK_DIV  = 24000,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned IOCTL_IDX = 3
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
`ifdef VOICE_SEQ_TEMPO_EN
  input  logic [15:0] tempo_div,
`endif
  output logic [15:0] tone_freq,
  output logic [3:0]  waveform_enable,
  output logic        gate,
  output logic [5:0]  step_idx,
  output logic        busy
);

  localparam int unsigned AW           = $clog2(STEPS);
  localparam logic [24:0] RAM_BYTES    = 25'(STEPS * STEP_BYTES);
  localparam logic [AW-1:0] LAST_IDX   = AW'(STEPS - 1);
  localparam logic [15:0] DEF_TICK_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_LEN      = 8'(GAP_TICKS);

  logic [1:0]    r_state, w_state_d;
  logic          r_load_ph, w_load_ph_d;
  logic [AW-1:0] r_idx, w_idx_d;
  logic [7:0]    r_left, w_left_d;
  logic [15:0]   r_tick_cnt;
  logic [15:0]   r_tone, w_tone_d;
  logic [3:0]    r_wave, w_wave_d;
  logic          r_rest, w_rest_d;

  logic          w_ram_we;
  logic [31:0]   w_rdata;
  step_t         w_step;
  logic          w_tick;
  logic [15:0]   w_tick_max;
  logic [1:0]    w_adv_state;
  logic [AW-1:0] w_adv_idx;

  // RAM is only writable while idle so a playing pattern never tears.
  assign w_ram_we = ioctl_wr && (ioctl_index == 8'(IOCTL_IDX)) &&
                    (ioctl_addr < RAM_BYTES) && (r_state == StIdle);

  voice_seq_ram #(
    .STEPS (STEPS),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_ram_we),
    .i_waddr (ioctl_addr[AW+1:2]),
    .i_lane  (ioctl_addr[1:0]),
    .i_wdata (ioctl_dout),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  assign w_step = unpack_step(w_rdata);

`ifdef VOICE_SEQ_TEMPO_EN
  logic [15:0] r_tick_max;

  // Tempo is captured on the first LOAD cycle so a change takes effect at the next step.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_tick_max <= DEF_TICK_MAX;
    end else if (r_state == StLoad && !r_load_ph) begin
      r_tick_max <= (tempo_div == 16'd0) ? DEF_TICK_MAX : tempo_div - 16'd1;
    end
  end

  assign w_tick_max = r_tick_max;
`else
  assign w_tick_max = DEF_TICK_MAX;
`endif

  assign w_tick = ((r_state == StHold) || (r_state == StGap)) && (r_tick_cnt == w_tick_max);

  // Held at zero outside HOLD/GAP, so a step's first tick lands TICK_DIV cycles into HOLD.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (!((r_state == StHold) || (r_state == StGap)) || w_tick || stop) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_comb begin
    w_adv_state = StLoad;
    w_adv_idx   = r_idx + AW'(1);
    if (r_idx == LAST_IDX) begin
      w_adv_idx   = '0;
      w_adv_state = loop_en ? StLoad : StIdle;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_load_ph_d = 1'b0;
    w_idx_d     = r_idx;
    w_left_d    = r_left;
    w_tone_d    = r_tone;
    w_wave_d    = r_wave;
    w_rest_d    = r_rest;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StLoad;
          w_idx_d   = '0;
        end
      end
      StLoad: begin
        if (!r_load_ph) begin
          w_load_ph_d = 1'b1;
        end else if (w_step.last) begin
          // An end marker at step 0 is an empty pattern; never loop on it.
          if ((r_idx != '0) && loop_en) begin
            w_idx_d   = '0;
            w_state_d = StLoad;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_tone_d  = w_step.freq;
          w_wave_d  = w_step.wave;
          w_rest_d  = w_step.rest;
          w_left_d  = (w_step.dur == 8'd0) ? 8'd1 : w_step.dur;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (w_tick) begin
          if (r_left > 8'd1) begin
            w_left_d = r_left - 8'd1;
          end else if (GAP_LEN == 8'd0) begin
            w_state_d = w_adv_state;
            w_idx_d   = w_adv_idx;
          end else begin
            w_state_d = StGap;
            w_left_d  = GAP_LEN;
          end
        end
      end
      StGap: begin
        if (w_tick) begin
          if (r_left > 8'd1) begin
            w_left_d = r_left - 8'd1;
          end else begin
            w_state_d = w_adv_state;
            w_idx_d   = w_adv_idx;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (stop) begin
      w_state_d   = StIdle;
      w_load_ph_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= StIdle;
      r_load_ph <= 1'b0;
      r_idx     <= '0;
      r_left    <= '0;
      r_tone    <= '0;
      r_wave    <= '0;
      r_rest    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_load_ph <= w_load_ph_d;
      r_idx     <= w_idx_d;
      r_left    <= w_left_d;
      r_tone    <= w_tone_d;
      r_wave    <= w_wave_d;
      r_rest    <= w_rest_d;
    end
  end

  assign tone_freq       = r_tone;
  assign waveform_enable = r_wave;
  assign gate            = (r_state == StHold) && !r_rest;
  assign busy            = (r_state != StIdle);
  assign step_idx        = 6'(r_idx);

endmodule

// File: tb/tb_voice_seq.sv
// tb_voice_seq: directed scoreboard bench for voice_seq with TICK_DIV=4, GAP_TICKS=2.
module tb_voice_seq;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [15:0] tone_freq;
  logic [3:0]  waveform_enable;
  logic        gate;
  logic [5:0]  step_idx;
  logic        busy;

  always #5 CLK = ~CLK;

  voice_seq #(
    .STEPS     (64),
    .TICK_DIV  (4),
    .GAP_TICKS (2),
    .IOCTL_IDX (3)
  ) dut (
    .CLK             (CLK),
    .rst             (rst),
    .ioctl_wr        (ioctl_wr),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .start           (start),
    .stop            (stop),
    .loop_en         (loop_en),
`ifdef VOICE_SEQ_TEMPO_EN
    .tempo_div       (16'd0),
`endif
    .tone_freq       (tone_freq),
    .waveform_enable (waveform_enable),
    .gate            (gate),
    .step_idx        (step_idx),
    .busy            (busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp_v;
    n_checks++;
    if (val_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: got %0h, nothing expected", obs);
    end else begin
      tag   = tag_q.pop_front();
      exp_v = val_q.pop_front();
      assert (obs === exp_v) else begin
        n_errors++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = d;
    @(negedge CLK);
    ioctl_wr    = 1'b0;
  endtask

  task automatic wr_step(input int s, input logic [15:0] f, input logic [7:0] c,
                         input logic [7:0] dur);
    wr_byte(8'd3, 25'(s * 4),     f[15:8]);
    wr_byte(8'd3, 25'(s * 4 + 1), f[7:0]);
    wr_byte(8'd3, 25'(s * 4 + 2), c);
    wr_byte(8'd3, 25'(s * 4 + 3), dur);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? gate : busy;
  endfunction

  // Counts negedges until the selected signal (0=gate, 1=busy) equals val, up to bound.
  task automatic run_until(input int sel, input logic val, input int bound, output int n);
    n = 0;
    while (sig(sel) !== val && n < bound) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   wraps;
    int   drops;
    logic seen;
    logic [5:0] prev;

    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    expect_val("rst_tone", 32'h0);
    expect_val("rst_wave", 32'h0);
    expect_val("rst_gate", 32'h0);
    expect_val("rst_idx", 32'h0);
    expect_val("rst_busy", 32'h0);
    observe(32'(tone_freq));
    observe(32'(waveform_enable));
    observe(32'(gate));
    observe(32'(step_idx));
    observe(32'(busy));

    // Single note, then end marker.
    wr_step(0, 16'h1125, 8'h01, 8'd3);
    wr_step(1, 16'h0000, 8'h80, 8'd0);
    expect_val("t1_gate_latency", 32'd2);
    expect_val("t1_tone", 32'h1125);
    expect_val("t1_wave", 32'h1);
    expect_val("t1_gate_high", 32'd12);
    expect_val("t1_gap_to_idle", 32'd10);
    expect_val("t1_idle_gate", 32'h0);
    expect_val("t1_held_tone", 32'h1125);
    expect_val("t1_end_idx", 32'd1);
    pulse_start();
    run_until(0, 1'b1, 50, n);
    observe(32'(n));
    observe(32'(tone_freq));
    observe(32'(waveform_enable));
    run_until(0, 1'b0, 50, n);
    observe(32'(n));
    run_until(1, 1'b0, 50, n);
    observe(32'(n));
    observe(32'(gate));
    observe(32'(tone_freq));
    observe(32'(step_idx));

    // Rest step: gate stays low for the whole pattern.
    wr_step(0, 16'h2000, 8'h41, 8'd2);
    expect_val("t2_first_idx", 32'd0);
    expect_val("t2_busy_len", 32'd20);
    expect_val("t2_gate_seen", 32'd0);
    expect_val("t2_tone", 32'h2000);
    expect_val("t2_end_idx", 32'd1);
    pulse_start();
    observe(32'(step_idx));
    n = 0;
    seen = 1'b0;
    while (busy !== 1'b0 && n < 100) begin
      seen = seen | gate;
      @(negedge CLK);
      n++;
    end
    observe(32'(n));
    observe(32'(seen));
    observe(32'(tone_freq));
    observe(32'(step_idx));

    // Two-step loop, then release loop_en.
    wr_step(0, 16'h0100, 8'h02, 8'd1);
    wr_step(1, 16'h0200, 8'h04, 8'd1);
    wr_step(2, 16'h0000, 8'h80, 8'd0);
    loop_en = 1'b1;
    expect_val("t3_wraps", 32'd2);
    expect_val("t3_busy_drops", 32'd0);
    expect_val("t3_saw_idx1", 32'd1);
    expect_val("t3_stopped", 32'd1);
    expect_val("t3_end_idx", 32'd2);
    pulse_start();
    wraps = 0;
    drops = 0;
    prev = step_idx;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1) drops++;
      if (prev == 6'd2 && step_idx == 6'd0) wraps++;
      prev = step_idx;
      @(negedge CLK);
    end
    loop_en = 1'b0;
    observe(32'(wraps));
    observe(32'(drops));
    n = 0;
    seen = 1'b0;
    while (busy !== 1'b0 && n < 100) begin
      if (step_idx == 6'd1) seen = 1'b1;
      @(negedge CLK);
      n++;
    end
    observe(32'(seen));
    observe(32'(n < 100));
    observe(32'(step_idx));

    // Stop mid-HOLD of step 1, stop-vs-start priority, then restart.
    wr_step(1, 16'h0200, 8'h04, 8'd3);
    expect_val("t4_reached_hold1", 32'd1);
    expect_val("t4_gate_after_stop", 32'd0);
    expect_val("t4_busy_after_stop", 32'd0);
    expect_val("t4_stop_wins", 32'd0);
    expect_val("t4_restart_idx", 32'd0);
    expect_val("t4_restart_busy", 32'd1);
    expect_val("t4_restart_done", 32'd1);
    pulse_start();
    n = 0;
    while (!(step_idx == 6'd1 && gate === 1'b1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    observe(32'(n < 200));
    repeat (3) @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    observe(32'(gate));
    observe(32'(busy));
    start = 1'b1;
    stop  = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    observe(32'(busy));
    pulse_start();
    observe(32'(step_idx));
    observe(32'(busy));
    run_until(1, 1'b0, 200, n);
    observe(32'(n < 200));

    // Writes while busy, to a foreign index and beyond the RAM must all be dropped.
    wr_step(0, 16'h1234, 8'h03, 8'd2);
    wr_step(1, 16'h0000, 8'h80, 8'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) wr_byte(8'd3, 25'(i), 8'hAA);
    run_until(1, 1'b0, 100, n);
    for (int i = 0; i < 4; i++) wr_byte(8'd2, 25'(i), 8'h55);
    for (int i = 0; i < 4; i++) wr_byte(8'd3, 25'(256 + i), 8'h77);
    expect_val("t5_tone", 32'h1234);
    expect_val("t5_wave", 32'h3);
    expect_val("t5_gate_high", 32'd8);
    expect_val("t5_end_idx", 32'd1);
    pulse_start();
    run_until(0, 1'b1, 50, n);
    observe(32'(tone_freq));
    observe(32'(waveform_enable));
    run_until(0, 1'b0, 50, n);
    observe(32'(n));
    run_until(1, 1'b0, 50, n);
    observe(32'(step_idx));

    // Reset during HOLD with a simultaneous start.
    expect_val("t6_tone", 32'h0);
    expect_val("t6_wave", 32'h0);
    expect_val("t6_gate", 32'h0);
    expect_val("t6_idx", 32'h0);
    expect_val("t6_busy", 32'h0);
    expect_val("t6_start_ignored", 32'h0);
    pulse_start();
    run_until(0, 1'b1, 50, n);
    @(negedge CLK);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    observe(32'(tone_freq));
    observe(32'(waveform_enable));
    observe(32'(gate));
    observe(32'(step_idx));
    observe(32'(busy));
    rst   = 1'b0;
    start = 1'b0;
    @(negedge CLK);
    observe(32'(busy));

    n_checks++;
    assert (val_q.size() === 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", val_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
